// File: rtl/sobel_gradient.sv
// Streaming Sobel edge-magnitude stage: builds a 3x3 window from three line taps
// and emits a saturated |Gx|+|Gy| per input beat, masked at frame and line borders.
module sobel_gradient #(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned DATA_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic [DATA_WIDTH-1:0] mid_in,
    input  logic [DATA_WIDTH-1:0] bot_in,
    output logic [DATA_WIDTH-1:0] grad_out,
    output logic                  grad_valid,
    output logic                  line_last
);

    localparam int unsigned CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int unsigned RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int unsigned SW = DATA_WIDTH + 4;

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [SW:0]   MAG_MAX  = (SW+1)'((2 ** DATA_WIDTH) - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DATA_WIDTH-1:0] win [0:2][0:2];
    logic                  s1_valid;
    logic                  s1_mask;
    logic                  s1_last;

    logic signed [SW-1:0]  gx;
    logic signed [SW-1:0]  gy;
    logic                  s2_valid;
    logic                  s2_mask;
    logic                  s2_last;

    logic signed [SW-1:0]  gx_c;
    logic signed [SW-1:0]  gy_c;
    logic [SW-1:0]         abs_gx_c;
    logic [SW-1:0]         abs_gy_c;
    logic [SW:0]           mag_c;
    logic [DATA_WIDTH-1:0] sat_c;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return signed'({{(SW-DATA_WIDTH){1'b0}}, v});
    endfunction

    // Position of the current bot_in beat within the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (data_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // S1: window shift; column 2 is newest, row 0 is the top tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
            s1_valid <= 1'b0;
            s1_mask  <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= data_valid;
            if (data_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= top_in;
                win[1][2] <= mid_in;
                win[2][2] <= bot_in;
                s1_mask   <= (col < CW'(2)) || (row < RW'(2));
                s1_last   <= (col == COL_LAST);
            end
        end
    end

    assign gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
                - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    assign gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
                - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

    // S2: signed gradients
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx       <= '0;
            gy       <= '0;
            s2_valid <= 1'b0;
            s2_mask  <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                gx      <= gx_c;
                gy      <= gy_c;
                s2_mask <= s1_mask;
                s2_last <= s1_last;
            end
        end
    end

    assign abs_gx_c = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    assign abs_gy_c = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    assign mag_c    = {1'b0, abs_gx_c} + {1'b0, abs_gy_c};
    assign sat_c    = (mag_c > MAG_MAX) ? MAG_MAX[DATA_WIDTH-1:0] : mag_c[DATA_WIDTH-1:0];

    // S3: magnitude, saturation and border mask; grad_out holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grad_out   <= '0;
            grad_valid <= 1'b0;
            line_last  <= 1'b0;
        end else begin
            grad_valid <= s2_valid;
            line_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                grad_out <= s2_mask ? '0 : sat_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed-vector bench for sobel_gradient: the driver queues hand-derived expectations,
// a negedge monitor pops and compares value, line_last and latency for every output.
module tb_sobel_gradient;

    localparam int unsigned LW = 10;
    localparam int unsigned FH = 5;
    localparam int unsigned DW = 6;

    localparam int K_FLAT   = 0;
    localparam int K_RAMP   = 1;
    localparam int K_EDGE10 = 2;
    localparam int K_EDGE63 = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_valid = 1'b0;
    logic [DW-1:0] top_in = '0;
    logic [DW-1:0] mid_in = '0;
    logic [DW-1:0] bot_in = '0;
    logic [DW-1:0] grad_out;
    logic          grad_valid;
    logic          line_last;

    sobel_gradient #(
        .LINE_WIDTH  (LW),
        .FRAME_HEIGHT(FH),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_valid(data_valid),
        .top_in    (top_in),
        .mid_in    (mid_in),
        .bot_in    (bot_in),
        .grad_out  (grad_out),
        .grad_valid(grad_valid),
        .line_last (line_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int grad;
        int last;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_grad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            K_FLAT:   return 20;
            K_RAMP:   return c + r;
            K_EDGE10: return (c >= 5) ? 10 : 0;
            default:  return (c >= 5) ? 63 : 0;
        endcase
    endfunction

    // Hand-derived results: ramp gives Gx=Gy=8, edge gives 4*step at cols 5,6
    function automatic int expv(input int kind, input int r, input int c);
        if (r < 2 || c < 2) return 0;
        case (kind)
            K_FLAT:   return 0;
            K_RAMP:   return 16;
            K_EDGE10: return (c == 5 || c == 6) ? 40 : 0;
            default:  return (c == 5 || c == 6) ? 63 : 0;
        endcase
    endfunction

    task automatic send_beat(input int kind, input int r, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        data_valid = 1'b1;
        bot_in = DW'(pix(kind, r, c));
        mid_in = (r >= 1) ? DW'(pix(kind, r - 1, c)) : '0;
        top_in = (r >= 2) ? DW'(pix(kind, r - 2, c)) : '0;
        e.grad = expv(kind, r, c);
        e.last = (c == LW - 1) ? 1 : 0;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        bot_in = DW'($urandom_range(63));
        mid_in = DW'($urandom_range(63));
        top_in = DW'($urandom_range(63));
    endtask

    task automatic send_frame(input int kind, input int gap);
        for (int r = 0; r < FH; r++) begin
            for (int c = 0; c < LW; c++) begin
                send_beat(kind, r, c);
                repeat (gap) idle();
            end
        end
    endtask

    // Scoreboard monitor, sampling away from the rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst_grad_valid", int'(grad_valid), 0);
            check("rst_grad_out", int'(grad_out), 0);
            check("rst_line_last", int'(line_last), 0);
            last_grad = 0;
        end else if (grad_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("grad_out", int'(grad_out), e.grad);
                check("line_last", int'(line_last), e.last);
                check("latency", cyc - e.cyc, 3);
                last_grad = e.grad;
            end
        end else begin
            check("hold_grad_out", int'(grad_out), last_grad);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        send_frame(K_FLAT, 0);
        repeat (4) idle();
        send_frame(K_RAMP, 0);
        send_frame(K_EDGE10, 0);
        send_frame(K_EDGE63, 0);
        repeat (2) idle();
        send_frame(K_RAMP, 2);

        // Mid-frame reset at beat 27, then a fresh ramp frame
        for (int i = 0; i < 27; i++) send_beat(K_RAMP, i / LW, i % LW);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(K_RAMP, 0);

        // Two consecutive frames without a gap
        send_frame(K_RAMP, 0);
        send_frame(K_RAMP, 0);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_gradient.md
Name: sobel_gradient

Overview:
- Streaming Sobel edge-magnitude stage. Sits directly downstream of the two cascaded line_delay instances.
- Each valid beat receives three vertically aligned pixels:
  - bot_in: current line, raw stream.
  - mid_in: one line delayed.
  - top_in: two lines delayed.
- Builds the 3x3 window, computes |Gx|+|Gy|, saturates the result, masks incomplete windows and emits one gradient pixel per input beat.
- Fixed pipeline latency; no backpressure.

Parameters:
- LINE_WIDTH, 640, pixels per line (must match line_delay LINE_WIDTH).
- FRAME_HEIGHT, 480, lines per frame.
- DATA_WIDTH, 6, bits per input and output pixel.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_valid  input  1  qualifies top_in/mid_in/bot_in this cycle.
- top_in  input  DATA_WIDTH  pixel two lines above current (second line_delay output).
- mid_in  input  DATA_WIDTH  pixel one line above current (first line_delay output).
- bot_in  input  DATA_WIDTH  current-line pixel.
- grad_out  output  DATA_WIDTH  saturated gradient magnitude.
- grad_valid  output  1  qualifies grad_out.
- line_last  output  1  high with grad_valid for the result of the input beat at column LINE_WIDTH-1.

Behaviour:
- Reset (async assert, release sync to clk):
  - grad_out=0, grad_valid=0, line_last=0.
  - Column counter col=0, row counter row=0.
  - All window registers and pipeline registers cleared to 0.
- Counters (advance only on data_valid):
  - col increments, wrapping LINE_WIDTH-1 -> 0.
  - On that wrap, row increments, wrapping FRAME_HEIGHT-1 -> 0.
  - col/row describe the position of the current bot_in beat.
- Window (shifts only on data_valid):
  - Column 0 = oldest, column 2 = newest {top,mid,bot}.
  - Row 0 = top, row 2 = bot.
  - With no data_valid, the window holds and the pipeline injects a bubble.
- Arithmetic, signed, width DATA_WIDTH+4. p[r][c] denotes window row r, column c.
  - Gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]).
  - Gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]).
  - mag = |Gx| + |Gy|.
  - grad_out = min(mag, 2^DATA_WIDTH-1).
- Masking:
  - If the beat that completed the window had col<2 or row<2, grad_out=0. The window then straddles a line or frame boundary, or contains rows from before reset.
  - grad_valid is still asserted for masked beats.
  - Output image is therefore offset by (+1,+1) relative to the window centre, with the first two columns and first two rows forced to 0.
- Pipeline: 3 stages, latency 3 cycles from the data_valid beat to grad_valid.
  - S1: window shift plus registered col/row mask flags.
  - S2: Gx and Gy.
  - S3: absolute values, sum, saturation, mask.
- Valid handling:
  - grad_valid equals data_valid delayed by exactly 3 cycles.
  - Idle cycles propagate as grad_valid=0; grad_out holds its last value during those cycles.
  - Back-to-back beats give back-to-back outputs.
- line_last is the delayed (col==LINE_WIDTH-1 && data_valid) flag, aligned with grad_valid.
- Reset mid-frame: the pipeline flushes immediately (no spurious grad_valid after release) and counters restart at row 0 / col 0.
- Frame wrap: the first beat of a new frame is row 0 and is masked. No state is carried across frames except window contents, which are masked anyway.

Test Plan:
Common setup: LINE_WIDTH=10, FRAME_HEIGHT=5, DATA_WIDTH=6.
- Flat frame, every pixel 20, data_valid held high -> 50 grad_valid beats, all grad_out=0, line_last on every 10th beat, first grad_valid 3 cycles after first data_valid.
- Ramp pixel=col+row, rows fed consistently through the taps -> beats with col>=2 and row>=2 give Gx=8, Gy=8, grad_out=16; all other beats give 0.
- Vertical edge, columns 0-4=0 and 5-9=10 -> grad_out=40 for beats at col 5 and col 6 (rows>=2), 0 elsewhere. Same test with 63 instead of 10 -> mag 252 saturates to grad_out=63.
- Ramp frame with data_valid toggling 1,0,0,1... -> grad_out sequence identical to the continuous run; each grad_valid exactly 3 cycles after its data_valid; no outputs in gap cycles.
- Assert rst at frame beat 27 for 2 cycles, then restart the ramp -> grad_valid low from reset assertion until 3 cycles after the first post-reset beat; first 20 post-reset outputs (rows 0-1) are 0.
- Two consecutive ramp frames -> second frame's row 0-1 outputs are 0; the remainder matches frame 1 exactly.
